// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and decoder state type, used by the VGA
// timing generator and the sync decoder.
package vga_timing_pkg;

   localparam int VGA_H_TOTAL     = 800;
   localparam int VGA_H_SYNC      = 96;
   localparam int VGA_H_BP        = 48;
   localparam int VGA_H_ACTIVE    = 640;
   localparam int VGA_V_TOTAL     = 525;
   localparam int VGA_V_SYNC      = 2;
   localparam int VGA_V_BP        = 33;
   localparam int VGA_V_ACTIVE    = 480;
   localparam int VGA_LOCK_FRAMES = 2;

   localparam int COORD_W = 16;

   typedef enum logic [1:0] {
      UNLOCKED,
      ACQUIRE,
      LOCKED
   } dec_state_t;

endpackage

// File: rtl/vga_sync_decoder_if.sv
// Sync inputs and recovered pixel-timing outputs of the VGA sync decoder.
// err_count is present only when VGA_DEC_ERR_CNT_EN is defined.
interface vga_sync_decoder_if;
   import vga_timing_pkg::*;

   logic               hsync_n;
   logic               vsync_n;
   logic [COORD_W-1:0] pixel_x;
   logic [COORD_W-1:0] pixel_y;
   logic               de;
   logic               frame_start;
   logic               locked;
   logic               timing_err;
`ifdef VGA_DEC_ERR_CNT_EN
   logic [7:0]         err_count;
`endif

   modport master (
      output hsync_n, vsync_n,
`ifdef VGA_DEC_ERR_CNT_EN
      input  err_count,
`endif
      input  pixel_x, pixel_y, de, frame_start, locked, timing_err
   );

   modport slave (
      input  hsync_n, vsync_n,
`ifdef VGA_DEC_ERR_CNT_EN
      output err_count,
`endif
      output pixel_x, pixel_y, de, frame_start, locked, timing_err
   );

endinterface

// File: rtl/sync_edge_det.sv
// Registers one sync input and flags its falling/rising edges from the
// registered and previous samples.
module sync_edge_det #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sync_i,
   output logic fall_o,
   output logic rise_o
);

   logic sync_q;
   logic prev_q;

   // Reset to the idle (deasserted) level so a sync already low after reset still yields an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= RESET_VAL;
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= sync_i;
         prev_q <= sync_q;
      end
   end

   assign fall_o = prev_q & ~sync_q;
   assign rise_o = ~prev_q & sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, data-enable and lock from hsync_n/vsync_n.
// Define VGA_DEC_ERR_CNT_EN to add the saturating 8-bit err_count output.
module vga_sync_decoder
   import vga_timing_pkg::*;
#(
   parameter int H_TOTAL     = VGA_H_TOTAL,
   parameter int H_SYNC      = VGA_H_SYNC,
   parameter int H_BP        = VGA_H_BP,
   parameter int H_ACTIVE    = VGA_H_ACTIVE,
   parameter int V_TOTAL     = VGA_V_TOTAL,
   parameter int V_SYNC      = VGA_V_SYNC,
   parameter int V_BP        = VGA_V_BP,
   parameter int V_ACTIVE    = VGA_V_ACTIVE,
   parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
   input logic               clk_25,
   input logic               rst_n,
   vga_sync_decoder_if.slave bus
);

   localparam logic [COORD_W-1:0] H_LAST      = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_SYNC_LAST = COORD_W'(H_SYNC - 1);
   localparam logic [COORD_W-1:0] H_SAT       = COORD_W'(2 * H_TOTAL);
   localparam logic [COORD_W-1:0] H_SAT_M1    = COORD_W'(2 * H_TOTAL - 1);
   localparam logic [COORD_W-1:0] H_START     = COORD_W'(H_SYNC + H_BP);
   localparam logic [COORD_W-1:0] H_END       = COORD_W'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [COORD_W-1:0] V_LAST      = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] V_START     = COORD_W'(V_SYNC + V_BP);
   localparam logic [COORD_W-1:0] V_END       = COORD_W'(V_SYNC + V_BP + V_ACTIVE);
   localparam int                 GF_W        = $clog2(LOCK_FRAMES + 1);
   localparam logic [GF_W-1:0]    GF_LAST     = GF_W'(LOCK_FRAMES - 1);

   logic hFall, hRise, vFall, unusedVRise;

   sync_edge_det uHsync (
      .clk    (clk_25),
      .rst_n  (rst_n),
      .sync_i (bus.hsync_n),
      .fall_o (hFall),
      .rise_o (hRise)
   );

   sync_edge_det uVsync (
      .clk    (clk_25),
      .rst_n  (rst_n),
      .sync_i (bus.vsync_n),
      .fall_o (vFall),
      .rise_o (unusedVRise)
   );

   logic [COORD_W-1:0] hPos_q, hPos_d, vPos_q, vPos_d;
   logic [COORD_W-1:0] pixelX_q, pixelY_q;
   logic               vPend_q, vPend_d;
   logic               hArmed_q, hArmed_d, vArmed_q, vArmed_d;
   logic [GF_W-1:0]    goodFrames_q, goodFrames_d;
   dec_state_t         state_q, state_d;
   logic               de_q, frameStart_q, locked_q, timingErr_q;
   logic               err, visible, lockedNext;

   // vPend remembers a vsync edge that arrived earlier in the current line.
   always_comb begin
      hPos_d  = hPos_q;
      vPos_d  = vPos_q;
      vPend_d = vPend_q;
      if (hFall) begin
         hPos_d  = '0;
         vPend_d = 1'b0;
         vPos_d  = (vFall || vPend_q) ? '0 : vPos_q + 1'b1;
      end else begin
         if (hPos_q != H_SAT) hPos_d = hPos_q + 1'b1;
         if (vFall) vPend_d = 1'b1;
      end
   end

   always_comb begin
      err = (hArmed_q && hFall && hPos_q != H_LAST)
         || (hArmed_q && hRise && hPos_q != H_SYNC_LAST)
         || (vArmed_q && vFall && vPos_q != V_LAST)
         || (hArmed_q && !hFall && hPos_q == H_SAT_M1);
      hArmed_d = !err && (hArmed_q || hFall);
      vArmed_d = !err && (vArmed_q || vFall);
   end

   always_comb begin
      state_d      = state_q;
      goodFrames_d = goodFrames_q;
      unique case (state_q)
         UNLOCKED: begin
            if (vFall && !err) begin
               state_d      = ACQUIRE;
               goodFrames_d = '0;
            end
         end
         ACQUIRE: begin
            if (err) begin
               state_d = UNLOCKED;
            end else if (vFall) begin
               goodFrames_d = goodFrames_q + 1'b1;
               if (goodFrames_q == GF_LAST) state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (err) state_d = UNLOCKED;
         end
         default: state_d = UNLOCKED;
      endcase
   end

   assign visible    = (hPos_d >= H_START) && (hPos_d < H_END)
                    && (vPos_d >= V_START) && (vPos_d < V_END);
   assign lockedNext = (state_d == LOCKED);

   // Outputs are registered from next-state values so de drops together with locked.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         hPos_q       <= '0;
         vPos_q       <= '0;
         vPend_q      <= 1'b0;
         hArmed_q     <= 1'b0;
         vArmed_q     <= 1'b0;
         goodFrames_q <= '0;
         state_q      <= UNLOCKED;
         pixelX_q     <= '0;
         pixelY_q     <= '0;
         de_q         <= 1'b0;
         frameStart_q <= 1'b0;
         locked_q     <= 1'b0;
         timingErr_q  <= 1'b0;
      end else begin
         hPos_q       <= hPos_d;
         vPos_q       <= vPos_d;
         vPend_q      <= vPend_d;
         hArmed_q     <= hArmed_d;
         vArmed_q     <= vArmed_d;
         goodFrames_q <= goodFrames_d;
         state_q      <= state_d;
         pixelX_q     <= visible ? hPos_d - H_START : '0;
         pixelY_q     <= visible ? vPos_d - V_START : '0;
         de_q         <= visible && lockedNext;
         frameStart_q <= lockedNext && hPos_d == H_START && vPos_d == V_START;
         locked_q     <= lockedNext;
         timingErr_q  <= err;
      end
   end

   assign bus.pixel_x     = pixelX_q;
   assign bus.pixel_y     = pixelY_q;
   assign bus.de          = de_q;
   assign bus.frame_start = frameStart_q;
   assign bus.locked      = locked_q;
   assign bus.timing_err  = timingErr_q;

`ifdef VGA_DEC_ERR_CNT_EN
   logic [7:0] errCount_q;

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n)                            errCount_q <= '0;
      else if (err && errCount_q != 8'hFF)   errCount_q <= errCount_q + 1'b1;
   end

   assign bus.err_count = errCount_q;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a shrunken 20x10 raster
// (sync 3/2, back porch 2/2, active 12x5) so frames stay short.
module tb_vga_sync_decoder;

   localparam int HT  = 20;
   localparam int HS  = 3;
   localparam int HBP = 2;
   localparam int HA  = 12;
   localparam int VT  = 10;
   localparam int VS  = 2;
   localparam int VBP = 2;
   localparam int VA  = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   vga_sync_decoder_if bus ();

   vga_sync_decoder #(
      .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA),
      .LOCK_FRAMES(2)
   ) dut (
      .clk_25 (clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int passes = 0;
   int gh = 0, gv = 0, lineLen = HT, lastH = -1, lastV = -1;
   bit hHold = 1'b0, shortAll = 1'b0;
   int deTotal = 0, fsTotal = 0, fsBadTotal = 0, errTotal = 0;
   int deStart, fsStart, fsBadStart, errStart;

   // Running tallies of output events, sampled away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.de) deTotal++;
         if (bus.timing_err) errTotal++;
         if (bus.frame_start) begin
            fsTotal++;
            if (bus.pixel_x != 16'd0 || bus.pixel_y != 16'd0) fsBadTotal++;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed === expected) passes++;
      else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #1;
      bus.hsync_n = hHold ? 1'b1 : (gh >= HS);
      bus.vsync_n = (gv >= VS);
      lastH = gh;
      lastV = gv;
      gh++;
      if (gh >= lineLen) begin
         gh      = 0;
         lineLen = shortAll ? HT - 1 : HT;
         gv      = (gv + 1) % VT;
      end
   endtask

   task automatic step();
      applyStimulus();
      @(negedge clk);
   endtask

   task automatic stepN(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic stepUntil(input int h, input int v);
      int n = 0;
      do begin
         step();
         n++;
      end while (!(lastH == h && lastV == v) && n < 2000);
      if (!(lastH == h && lastV == v)) checkOutput("stepUntil bound", 0, 1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " pixel_x"}, 32'(bus.pixel_x), 0);
      checkOutput({tag, " pixel_y"}, 32'(bus.pixel_y), 0);
      checkOutput({tag, " de"}, 32'(bus.de), 0);
      checkOutput({tag, " frame_start"}, 32'(bus.frame_start), 0);
      checkOutput({tag, " locked"}, 32'(bus.locked), 0);
      checkOutput({tag, " timing_err"}, 32'(bus.timing_err), 0);
   endtask

   task automatic checkPixel(input int h, input int v, input int px, input int py,
                             input int deExp);
      stepUntil(h, v);
      stepN(2);
      checkOutput($sformatf("pixel_x @%0d,%0d", h, v), 32'(bus.pixel_x), px);
      checkOutput($sformatf("pixel_y @%0d,%0d", h, v), 32'(bus.pixel_y), py);
      checkOutput($sformatf("de @%0d,%0d", h, v), 32'(bus.de), deExp);
   endtask

   initial begin
      bus.hsync_n = 1'b1;
      bus.vsync_n = 1'b1;
      repeat (3) @(negedge clk);
      checkAllZero("reset");
`ifdef VGA_DEC_ERR_CNT_EN
      checkOutput("reset err_count", 32'(bus.err_count), 0);
`endif
      rst_n = 1'b1;

      // Lock from reset: third vsync edge, locked two cycles later.
      stepUntil(0, 0);
      stepUntil(0, 0);
      stepUntil(0, 0);
      step();
      checkOutput("lock +1 cycle", 32'(bus.locked), 0);
      step();
      checkOutput("lock +2 cycles", 32'(bus.locked), 1);

      deStart = deTotal; fsStart = fsTotal; fsBadStart = fsBadTotal; errStart = errTotal;
      stepUntil(0, 0);
      checkOutput("de per frame", deTotal - deStart, HA * VA);
      checkOutput("frame_start per frame", fsTotal - fsStart, 1);
      checkOutput("frame_start coords", fsBadTotal - fsBadStart, 0);
      checkOutput("no err clean frame", errTotal - errStart, 0);

      checkPixel(4, 5, 0, 0, 0);
      checkPixel(10, 5, 5, 1, 1);
      checkPixel(16, 8, 11, 4, 1);
      checkPixel(16, 9, 0, 0, 0);
      checkOutput("locked before short line", 32'(bus.locked), 1);

      // One 19-clock line, then clean timing again.
      stepUntil(HT - 1, 2);
      lineLen = HT - 1;
      errStart = errTotal;
      stepUntil(0, 4);
      step();
      checkOutput("short line err early", 32'(bus.timing_err), 0);
      step();
      checkOutput("short line err pulse", 32'(bus.timing_err), 1);
      step();
      checkOutput("short line err width", 32'(bus.timing_err), 0);
      checkOutput("short line unlock", 32'(bus.locked), 0);
      stepN(5);
      checkOutput("short line err count", errTotal - errStart, 1);
      stepUntil(0, 0);
      stepUntil(0, 0);
      stepUntil(0, 0);
      step();
      checkOutput("relock +1 cycle", 32'(bus.locked), 0);
      step();
      checkOutput("relock +2 cycles", 32'(bus.locked), 1);

      // hsync held high past twice the line length.
      stepUntil(10, 5);
      hHold = 1'b1;
      errStart = errTotal;
      stepN(50);
      checkOutput("hsync lost err count", errTotal - errStart, 1);
      checkOutput("hsync lost unlock", 32'(bus.locked), 0);
      checkOutput("hsync lost de", 32'(bus.de), 0);
      hHold = 1'b0;
      stepUntil(0, 0);
      stepUntil(0, 0);
      stepUntil(0, 0);
      stepN(2);
      checkOutput("relock after hsync loss", 32'(bus.locked), 1);

      // Asynchronous reset in the middle of a visible line.
      stepUntil(10, 6);
      stepN(2);
      checkOutput("de before mid reset", 32'(bus.de), 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkAllZero("mid reset");
      @(negedge clk);
      rst_n = 1'b1;
      stepUntil(0, 0);
      stepUntil(0, 0);
      stepN(2);
      checkOutput("reacquire after 2 vsync", 32'(bus.locked), 0);
      stepUntil(0, 0);
      step();
      checkOutput("reacquire 3rd vsync +1", 32'(bus.locked), 0);
      step();
      checkOutput("reacquire 3rd vsync +2", 32'(bus.locked), 1);

`ifdef VGA_DEC_ERR_CNT_EN
      // Every line short: an error on every other hsync edge, well over 255.
      shortAll = 1'b1;
      stepN(650 * (HT - 1));
      checkOutput("err_count saturates", 32'(bus.err_count), 255);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart to the VGA timing generator: samples `hsync_n`/`vsync_n` in the 25 MHz pixel domain and recovers pixel coordinates and a data-enable. It checks every line and frame against the 640x480@60 timing and reports lock. It sits between the generator (or a capture input) and pixel consumers such as the Morse/keyboard text overlay. It also lets the bench check the generator in a closed loop.

## Interface
- `H_TOTAL`, 800, clocks per line
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BP`, 48, back porch after hsync
- `H_ACTIVE`, 640, visible pixels per line
- `V_TOTAL`, 525, lines per frame
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, back porch lines after vsync
- `V_ACTIVE`, 480, visible lines
- `LOCK_FRAMES`, 2, consecutive clean frames needed to lock
- `clk_25`  in  1  pixel clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `hsync_n`  in  1  horizontal sync, active low, synchronous to `clk_25`
- `vsync_n`  in  1  vertical sync, active low, synchronous to `clk_25`
- `pixel_x`  out  16  active column 0..H_ACTIVE-1; 0 outside the active area
- `pixel_y`  out  16  active row 0..V_ACTIVE-1; 0 outside the active area
- `de`  out  1  high when the current pixel is visible and the state is LOCKED
- `frame_start`  out  1  one-cycle pulse when the first active pixel (0,0) is presented while LOCKED
- `locked`  out  1  high in state LOCKED
- `timing_err`  out  1  one-cycle pulse on any detected timing violation

## Operation
- Input stage: `hsync_n` and `vsync_n` registered once; falling and rising edges detected from the registered and previous values.
- `h_pos` (16 b) resets to 0 on each hsync falling edge, otherwise increments, saturating at `2*H_TOTAL`.
- `v_pos` (16 b) increments on each hsync falling edge and resets to 0 when a vsync falling edge coincides with or precedes that hsync edge in the same line. A vsync edge and an hsync edge in the same cycle are legal and give `h_pos=0`, `v_pos=0`.
- Active area: `h_pos` in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE) and `v_pos` in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE).
  - `pixel_x = h_pos-(H_SYNC+H_BP)`, `pixel_y = v_pos-(V_SYNC+V_BP)`.
- Violations, each pulsing `timing_err` once:
  - hsync falling edge with `h_pos != H_TOTAL-1`
  - hsync rising edge with `h_pos != H_SYNC-1`
  - vsync falling edge with `v_pos != V_TOTAL-1`
  - `h_pos` reaching `2*H_TOTAL` (hsync lost)
- Checks are armed only after the first hsync and vsync edges seen since reset or loss of lock.
- FSM:
  - UNLOCKED: wait for a vsync falling edge, then go to ACQUIRE with `good_frames=0`.
  - ACQUIRE: each clean vsync falling edge increments `good_frames`; at `LOCK_FRAMES`, go to LOCKED. Any violation returns to UNLOCKED.
  - LOCKED: any violation returns to UNLOCKED; `locked` drops the next cycle.
- Reset values: `pixel_x=0`, `pixel_y=0`, `de=0`, `frame_start=0`, `locked=0`, `timing_err=0`; state UNLOCKED; all counters 0.

## Timing
- Latency: outputs describe the sync inputs sampled two `clk_25` edges earlier (input register plus counter/output register).
- All outputs are registered; there are no combinational paths from input to output.
- With a conforming generator, `locked` rises 2 cycles after the vsync falling edge that completes `LOCK_FRAMES` clean frames after the first vsync.
- `de` is forced low in the same cycle as `locked` is deasserted.
- Asserting `rst_n` low mid-frame clears all state immediately; reacquisition then needs a full `LOCK_FRAMES+1` vsync edges.

## Configuration
- Macro `VGA_DEC_ERR_CNT_EN`.
  - Defined: adds output `err_count` (8 b), which increments on every `timing_err` pulse, saturates at 255, and clears only on reset.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the 640x480 timing constants, used as parameter defaults by both the generator and this block
  - the `dec_state_t` enum (UNLOCKED, ACQUIRE, LOCKED)
  - the 16-bit coordinate width constant
- One sub-module, `sync_edge_det`: one-flop register plus falling/rising pulse outputs, instanced once for each sync input.

## Test plan
- Conforming 640x480 stream from reset -> `locked`=1 after the 3rd vsync falling edge (+2 cycles); `de` high for exactly 640x480 cycles per frame; `frame_start` once per frame with `pixel_x=0`, `pixel_y=0`.
- While locked, shorten one line to 799 clocks -> `timing_err` pulses once and `locked`=0 the next cycle. Resume clean timing -> relock after 2 clean frames.
- Hold `hsync_n` high for 1600 clocks -> `timing_err` pulse, state UNLOCKED, `de`=0.
- vsync falling edge in the same cycle as hsync falling edge -> no error; `v_pos`=0 and `h_pos`=0 two cycles later.
- Pull `rst_n` low at line 200 of a locked frame -> all outputs 0 immediately.
- With `VGA_DEC_ERR_CNT_EN`, inject 300 errors -> `err_count`=255.
